// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller.
// Cycles IDLE -> BLANK -> DRIVE per digit. Digit data is double-buffered
// (staging -> shadow) so a new value only becomes visible at a frame boundary.
// Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to suppress leading zeros.
module seg7_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned BLANK_CYCLES = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      show_a2f,
  output logic [3:0]                hex,
  output logic                      show_a2f_out,
  output logic [NUM_DIGITS-1:0]     digit_sel,
  output logic                      dp,
  output logic                      frame_done,
  output logic                      load_ack
);

  localparam int unsigned IdxW   = $clog2(NUM_DIGITS);
  localparam int unsigned CntMax = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [IdxW-1:0] LastIdx   = IdxW'(NUM_DIGITS - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] DwellLast = CntW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBlank, StDrive} state_e;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    wrap;

  logic [4*NUM_DIGITS-1:0] stage_val_q, stage_val_d;
  logic [NUM_DIGITS-1:0]   stage_dp_q, stage_dp_d;
  logic                    stage_show_q, stage_show_d;
  logic                    pending_q, pending_d;

  logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic                    shadow_show_q, shadow_show_d;

  logic [3:0]              hex_q, hex_d;
  logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;
  logic                    dp_q, dp_d;
  logic                    frame_done_q;
  logic                    load_ack_q, load_ack_d;
  logic                    lz_blank;

  // Scan sequencing: enable low forces IDLE; otherwise walk BLANK/DRIVE per digit.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap    = 1'b0;
    if (!enable) begin
      state_d = StIdle;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StBlank;
          idx_d   = '0;
          cnt_d   = '0;
        end
        StBlank: begin
          if (cnt_q == BlankLast) begin
            state_d = StDrive;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StDrive: begin
          if (cnt_q == DwellLast) begin
            state_d = StBlank;
            cnt_d   = '0;
            if (idx_q == LastIdx) begin
              idx_d = '0;
              wrap  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Load buffering: staging always takes the latest load; shadow only changes at
  // a frame wrap (or while idle) so a frame never mixes old and new digits.
  always_comb begin
    stage_val_d   = stage_val_q;
    stage_dp_d    = stage_dp_q;
    stage_show_d  = stage_show_q;
    pending_d     = pending_q;
    shadow_val_d  = shadow_val_q;
    shadow_dp_d   = shadow_dp_q;
    shadow_show_d = shadow_show_q;
    load_ack_d    = 1'b0;
    if (load) begin
      stage_val_d  = value;
      stage_dp_d   = dp_in;
      stage_show_d = show_a2f;
      pending_d    = 1'b1;
    end
    if (wrap) begin
      if (load) begin
        // Same-cycle load bypasses staging straight into the new frame.
        shadow_val_d  = value;
        shadow_dp_d   = dp_in;
        shadow_show_d = show_a2f;
        pending_d     = 1'b0;
        load_ack_d    = 1'b1;
      end else if (pending_q) begin
        shadow_val_d  = stage_val_q;
        shadow_dp_d   = stage_dp_q;
        shadow_show_d = stage_show_q;
        pending_d     = 1'b0;
        load_ack_d    = 1'b1;
      end
    end else if (state_q == StIdle && pending_q) begin
      shadow_val_d  = stage_val_q;
      shadow_dp_d   = stage_dp_q;
      shadow_show_d = stage_show_q;
      pending_d     = load;
      load_ack_d    = 1'b1;
    end
  end

  // Registered outputs derived from next state so they align with the state.
  always_comb begin
    lz_blank = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (idx_d != '0) begin
      lz_blank = 1'b1;
      for (int k = 0; k < int'(NUM_DIGITS); k++) begin
        if (k >= int'(idx_d) && (shadow_val_d[4*k +: 4] != 4'h0 || shadow_dp_d[k])) begin
          lz_blank = 1'b0;
        end
      end
    end
`endif
    hex_d       = shadow_val_d[4*int'(idx_d) +: 4];
    digit_sel_d = '0;
    dp_d        = 1'b0;
    if (state_d == StDrive && !lz_blank) begin
      digit_sel_d = NUM_DIGITS'(1) << idx_d;
      dp_d        = shadow_dp_d[idx_d];
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      cnt_q         <= '0;
      stage_val_q   <= '0;
      stage_dp_q    <= '0;
      stage_show_q  <= 1'b0;
      pending_q     <= 1'b0;
      shadow_val_q  <= '0;
      shadow_dp_q   <= '0;
      shadow_show_q <= 1'b0;
      hex_q         <= '0;
      digit_sel_q   <= '0;
      dp_q          <= 1'b0;
      frame_done_q  <= 1'b0;
      load_ack_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      stage_val_q   <= stage_val_d;
      stage_dp_q    <= stage_dp_d;
      stage_show_q  <= stage_show_d;
      pending_q     <= pending_d;
      shadow_val_q  <= shadow_val_d;
      shadow_dp_q   <= shadow_dp_d;
      shadow_show_q <= shadow_show_d;
      hex_q         <= hex_d;
      digit_sel_q   <= digit_sel_d;
      dp_q          <= dp_d;
      frame_done_q  <= wrap;
      load_ack_q    <= load_ack_d;
    end
  end

  assign hex          = hex_q;
  assign show_a2f_out = shadow_show_q;
  assign digit_sel    = digit_sel_q;
  assign dp           = dp_q;
  assign frame_done   = frame_done_q;
  assign load_ack     = load_ack_q;

endmodule
